iram_byte_loader: RTL and testbench
===================================

IRAM_BYTE_LOADER -- requirements
Module: iram_byte_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 40'h0, byte address of the first 128-bit word written after reset or ld_start.
REQ-002 SHALL have parameter AXI_ID, default 8'h0, constant value driven on awid_m.
REQ-003 SHALL have port pll_core_cpuclk, input, 1, the single clock; all flops on its rising edge.
REQ-004 SHALL have port pad_cpu_rst_b, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port ld_start, input, 1, single-cycle pulse that restarts loading at BASE_ADDR.
REQ-006 SHALL have ports byte_valid (input, 1), byte_data (input, 8) and byte_ready (output, 1), forming the byte stream handshake.
REQ-007 SHALL have port ld_flush, input, 1, which forces out a partially filled word.
REQ-008 SHALL have port ld_busy, output, 1, high while an AXI write is in flight.
REQ-009 SHALL have port ld_word_cnt, output, 16, count of completed AXI writes.
REQ-010 SHALL have port ld_err, output, 1, sticky flag for any non-zero bresp_m.
REQ-011 SHALL have AW outputs awaddr_m (40), awid_m (8), awlen_m (8), awsize_m (3), awburst_m (2) and awvalid_m (1), plus input awready_m (1).
REQ-012 SHALL have W outputs wdata_m (128), wstrb_m (16), wlast_m (1) and wvalid_m (1), plus input wready_m (1).
REQ-013 SHALL have B inputs bvalid_m (1), bid_m (8) and bresp_m (2), plus output bready_m (1).
REQ-014 SHALL NOT generate awcache, awprot or wid; the top level ties these off.

Function
REQ-015 SHALL implement an FSM with states FILL, ADDR, DATA and RESP.
REQ-016 In FILL, SHALL drive byte_ready=1 iff byte_cnt<16.
REQ-017 On byte_valid&&byte_ready, SHALL store byte k at buffer[8k+7:8k], set strobe bit k, and increment byte_cnt.
REQ-018 When byte_cnt reaches 16, SHALL move FILL->ADDR on the next edge.
REQ-019 If ld_flush is high in FILL with byte_cnt>0, SHALL move FILL->ADDR, with wstrb_m equal to the accumulated strobes.
REQ-020 SHALL ignore ld_flush when byte_cnt==0.
REQ-021 If ld_flush coincides with an accepted byte, SHALL include that byte in the flushed word.
REQ-022 If ld_flush coincides with the 16th accepted byte, SHALL issue one full write only.
REQ-023 In ADDR, SHALL assert awvalid_m with awaddr_m=cur_addr, awlen_m=0, awsize_m=3'b100, awburst_m=2'b01 and awid_m=AXI_ID.
REQ-024 SHALL hold all AW outputs stable until awready_m, then move ADDR->DATA.
REQ-025 In DATA, SHALL assert wvalid_m and wlast_m=1 with wdata_m=buffer, holding all W outputs stable until wready_m, then move DATA->RESP.
REQ-026 SHALL drive byte bits with a clear strobe as 0 in wdata_m.
REQ-027 In RESP, SHALL drive bready_m=1.
REQ-028 On bvalid_m, SHALL set cur_addr+=40'h10 (mod 2^40), increment ld_word_cnt (wrapping FFFF->0), clear byte_cnt and strobes, and return to FILL.
REQ-029 SHALL set ld_err=1 on bvalid_m&&bresp_m!=0; ld_err clears only on reset or ld_start.
REQ-030 SHALL NOT check bid_m.
REQ-031 SHALL drive ld_busy = (state!=FILL).
REQ-032 SHALL drive byte_ready=0 whenever state!=FILL.
REQ-033 On ld_start in FILL, SHALL set cur_addr=BASE_ADDR, discard buffered bytes, clear ld_word_cnt and ld_err, and not accept a byte that cycle.
REQ-034 SHALL ignore ld_start in ADDR, DATA and RESP.
REQ-035 SHALL hold awvalid_m, wvalid_m and bready_m at 0 outside their own states.
REQ-036 SHALL allow a minimum of 1 cycle per state when AXI ready/valid signals are already high, giving FILL->FILL for one word in at least 3 cycles after the 16th byte.

Reset
REQ-037 While pad_cpu_rst_b=0, SHALL asynchronously put the FSM in FILL with cur_addr=BASE_ADDR, byte_cnt=0, strobes=0 and buffer=0.
REQ-038 During reset, SHALL drive outputs ld_word_cnt=0, ld_err=0, ld_busy=0, byte_ready=1, awvalid_m=0, wvalid_m=0 and bready_m=0.
REQ-039 On reset asserted mid-transaction, SHALL abort the transaction immediately with no completion signalled.

Verification
REQ-040 Send 16 bytes 0x00..0x0F with awready_m, wready_m and bvalid_m tied to 1 -> one write at awaddr_m=BASE_ADDR with wdata_m=128'h0F0E..0100, wstrb_m=16'hFFFF, ld_word_cnt=1.
REQ-041 Send 3 bytes then pulse ld_flush -> wstrb_m=16'h0007, wdata_m[127:24]=0, next write address advances by 0x10.
REQ-042 Hold awready_m=0 for 5 cycles -> awvalid_m stays high with stable awaddr_m; byte_ready=0 throughout.
REQ-043 Return bresp_m=2'b10 -> ld_err=1 persisting through later OKAY writes; ld_start clears it, and the next write goes to BASE_ADDR.
REQ-044 Assert ld_flush on the same cycle as the 16th byte -> exactly one write, with wstrb_m=16'hFFFF.
REQ-045 Pull pad_cpu_rst_b low while in DATA -> wvalid_m=0 immediately; after release the FSM is in FILL and ld_word_cnt=0.

Source files
------------

// File: rtl/iram_byte_loader.sv
// Packs an 8-bit byte stream into 128-bit words and writes each word to
// instruction RAM as a single-beat AXI write, one word outstanding at a time.
module iram_byte_loader #(
    parameter logic [39:0] BASE_ADDR = 40'h0,
    parameter logic [7:0]  AXI_ID    = 8'h0
) (
    input  logic         pll_core_cpuclk,
    input  logic         pad_cpu_rst_b,
    input  logic         ld_start,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    output logic         byte_ready,
    input  logic         ld_flush,
    output logic         ld_busy,
    output logic [15:0]  ld_word_cnt,
    output logic         ld_err,
    output logic [39:0]  awaddr_m,
    output logic [7:0]   awid_m,
    output logic [7:0]   awlen_m,
    output logic [2:0]   awsize_m,
    output logic [1:0]   awburst_m,
    output logic         awvalid_m,
    input  logic         awready_m,
    output logic [127:0] wdata_m,
    output logic [15:0]  wstrb_m,
    output logic         wlast_m,
    output logic         wvalid_m,
    input  logic         wready_m,
    input  logic         bvalid_m,
    input  logic [7:0]   bid_m,
    input  logic [1:0]   bresp_m,
    output logic         bready_m
);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     byte_cnt_q, byte_cnt_d;
    logic [15:0]    strb_q, strb_d;
    logic [127:0]   buf_q, buf_d;
    logic [39:0]    cur_addr_q, cur_addr_d;
    logic [15:0]    word_cnt_q, word_cnt_d;
    logic           err_q, err_d;
    logic           byte_ready_q, byte_ready_d;
    logic           busy_q, busy_d;
    logic           awvalid_q, awvalid_d;
    logic           wvalid_q, wvalid_d;
    logic           bready_q, bready_d;
    logic           accept_s;
    logic           unused_bid_s;

    // Response ID is deliberately not checked; only one write is ever in flight.
    assign unused_bid_s = ^bid_m;

    // Next-state computation for the FSM, word buffer and status counters.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        strb_d     = strb_q;
        buf_d      = buf_q;
        cur_addr_d = cur_addr_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;
        accept_s   = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (ld_start) begin
                    cur_addr_d = BASE_ADDR;
                    byte_cnt_d = 5'd0;
                    strb_d     = 16'h0000;
                    buf_d      = 128'h0;
                    word_cnt_d = 16'h0000;
                    err_d      = 1'b0;
                    state_d    = ST_FILL;
                end else begin
                    // byte_ready_q is only high in FILL with room left in the word
                    accept_s = byte_valid && byte_ready_q;
                    if (accept_s) begin
                        buf_d[{byte_cnt_q[3:0], 3'b000} +: 8] = byte_data;
                        strb_d[byte_cnt_q[3:0]]               = 1'b1;
                        byte_cnt_d                            = byte_cnt_q + 5'd1;
                    end else begin
                        byte_cnt_d = byte_cnt_q;
                    end
                    if ((byte_cnt_q == 5'd16) || (ld_flush && (byte_cnt_d != 5'd0))) begin
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_ADDR: begin
                if (awready_m) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (wready_m) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (bvalid_m) begin
                    cur_addr_d = cur_addr_q + 40'h10;
                    word_cnt_d = word_cnt_q + 16'h0001;
                    err_d      = err_q | (bresp_m != 2'b00);
                    byte_cnt_d = 5'd0;
                    strb_d     = 16'h0000;
                    buf_d      = 128'h0;
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they are registered.
    always_comb begin
        awvalid_d    = (state_d == ST_ADDR);
        wvalid_d     = (state_d == ST_DATA);
        bready_d     = (state_d == ST_RESP);
        busy_d       = (state_d != ST_FILL);
        byte_ready_d = (state_d == ST_FILL) && (byte_cnt_d < 5'd16);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state_q      <= ST_FILL;
            byte_cnt_q   <= 5'd0;
            strb_q       <= 16'h0000;
            buf_q        <= 128'h0;
            cur_addr_q   <= BASE_ADDR;
            word_cnt_q   <= 16'h0000;
            err_q        <= 1'b0;
            byte_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            strb_q       <= strb_d;
            buf_q        <= buf_d;
            cur_addr_q   <= cur_addr_d;
            word_cnt_q   <= word_cnt_d;
            err_q        <= err_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
        end
    end

    assign byte_ready  = byte_ready_q;
    assign ld_busy     = busy_q;
    assign ld_word_cnt = word_cnt_q;
    assign ld_err      = err_q;

    assign awaddr_m  = cur_addr_q;
    assign awid_m    = AXI_ID;
    assign awlen_m   = 8'h00;
    assign awsize_m  = 3'b100;
    assign awburst_m = 2'b01;
    assign awvalid_m = awvalid_q;

    // Unwritten byte lanes stay zero because the buffer is cleared per word.
    assign wdata_m  = buf_q;
    assign wstrb_m  = strb_q;
    assign wlast_m  = wvalid_q;
    assign wvalid_m = wvalid_q;

    assign bready_m = bready_q;

endmodule

// File: tb/tb_iram_byte_loader.sv
// Randomized bench for iram_byte_loader: a transaction-level model predicts
// each AXI write (address, data, strobes) and the status outputs.
module tb_iram_byte_loader;

    localparam logic [39:0] BASE = 40'h00_1234_5600;
    localparam logic [7:0]  ID   = 8'h5A;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ld_start, byte_valid, ld_flush;
    logic [7:0]   byte_data;
    logic         byte_ready, ld_busy, ld_err;
    logic [15:0]  ld_word_cnt;
    logic [39:0]  awaddr;
    logic [7:0]   awid, awlen, bid;
    logic [2:0]   awsize;
    logic [1:0]   awburst, bresp;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;

    iram_byte_loader #(.BASE_ADDR(BASE), .AXI_ID(ID)) dut (
        .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_n), .ld_start(ld_start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .ld_flush(ld_flush), .ld_busy(ld_busy), .ld_word_cnt(ld_word_cnt), .ld_err(ld_err),
        .awaddr_m(awaddr), .awid_m(awid), .awlen_m(awlen), .awsize_m(awsize),
        .awburst_m(awburst), .awvalid_m(awvalid), .awready_m(awready),
        .wdata_m(wdata), .wstrb_m(wstrb), .wlast_m(wlast), .wvalid_m(wvalid), .wready_m(wready),
        .bvalid_m(bvalid), .bid_m(bid), .bresp_m(bresp), .bready_m(bready)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        logic [39:0]  addr;
        logic [127:0] data;
        logic [15:0]  strb;
    } wr_t;

    logic [39:0] m_addr;
    logic [15:0] m_wcnt;
    logic        m_err;
    logic [7:0]  m_bytes[$];
    wr_t         m_exp[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void close_word();
        wr_t w;
        w.addr = m_addr;
        w.data = '0;
        w.strb = '0;
        for (int i = 0; i < m_bytes.size(); i++) begin
            w.data[i*8 +: 8] = m_bytes[i];
            w.strb[i]        = 1'b1;
        end
        m_exp.push_back(w);
        m_bytes.delete();
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic fl);
        int t = 0;
        while (!byte_ready && t < 50) begin step(); t++; end
        if (!byte_ready) begin
            chk("byte_ready_timeout", byte_ready, 1'b1);
            return;
        end
        byte_valid = 1'b1; byte_data = d; ld_flush = fl;
        step();
        byte_valid = 1'b0; ld_flush = 1'b0;
        m_bytes.push_back(d);
        if (fl || m_bytes.size() == 16) close_word();
    endtask

    task automatic flush_only();
        int t = 0;
        while (ld_busy && t < 50) begin step(); t++; end
        ld_flush = 1'b1;
        step();
        ld_flush = 1'b0;
        if (m_bytes.size() > 0) close_word();
    endtask

    task automatic start_pulse();
        int t = 0;
        while (ld_busy && t < 50) begin step(); t++; end
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        m_addr = BASE; m_wcnt = 16'h0; m_err = 1'b0;
        m_bytes.delete();
        chk("start_clears", {ld_word_cnt, ld_err, ld_busy}, {16'h0, 1'b0, 1'b0});
    endtask

    // Acts as the AXI slave for one write, with the given per-channel stall cycles.
    task automatic serve_write(input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp);
        wr_t e;
        int  t = 0;
        chk("exp_pending", m_exp.size(), 1);
        if (m_exp.size() == 0) return;
        e = m_exp.pop_front();
        while (!awvalid && t < 50) begin step(); t++; end
        if (!awvalid) begin chk("aw_timeout", awvalid, 1'b1); return; end
        for (int i = 0; i < aw_dly; i++) begin
            chk("aw_hold", {awvalid, byte_ready, ld_busy, awaddr}, {1'b1, 1'b0, 1'b1, e.addr});
            step();
        end
        awready = 1'b1;
        chk("awaddr", awaddr, e.addr);
        chk("aw_attr", {awlen, awsize, awburst, awid, wvalid, bready},
            {8'h00, 3'b100, 2'b01, ID, 1'b0, 1'b0});
        step();
        awready = 1'b0;
        t = 0;
        while (!wvalid && t < 50) begin step(); t++; end
        if (!wvalid) begin chk("w_timeout", wvalid, 1'b1); return; end
        for (int i = 0; i < w_dly; i++) begin
            chk("w_hold", {wvalid, wlast, byte_ready, awvalid, wstrb}, {1'b1, 1'b1, 1'b0, 1'b0, e.strb});
            step();
        end
        wready = 1'b1;
        chk("wdata", wdata, e.data);
        chk("wstrb", {wlast, wstrb}, {1'b1, e.strb});
        step();
        wready = 1'b0;
        t = 0;
        while (!bready && t < 50) begin step(); t++; end
        if (!bready) begin chk("b_timeout", bready, 1'b1); return; end
        for (int i = 0; i < b_dly; i++) begin
            chk("b_hold", {bready, wvalid, byte_ready, ld_busy}, {1'b1, 1'b0, 1'b0, 1'b1});
            step();
        end
        bvalid = 1'b1; bresp = resp; bid = 8'($urandom);
        step();
        bvalid = 1'b0; bresp = 2'b00;
        m_addr = m_addr + 40'h10;
        m_wcnt = m_wcnt + 16'h1;
        m_err  = m_err | (resp != 2'b00);
        chk("after_b", {ld_word_cnt, ld_err, ld_busy, byte_ready, bready},
            {m_wcnt, m_err, 1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic fl;
        rst_n = 1'b0; ld_start = 1'b0; byte_valid = 1'b0; ld_flush = 1'b0; byte_data = 8'h00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 8'h00; bresp = 2'b00;
        m_addr = BASE; m_wcnt = 16'h0; m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {byte_ready, ld_busy, awvalid, wvalid, bready, ld_err, ld_word_cnt},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
        rst_n = 1'b1;
        step();

        // Full word of 0x00..0x0F with no stalls.
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        serve_write(0, 0, 0, 2'b00);

        // Three bytes closed by a separate flush pulse.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        flush_only();
        serve_write(0, 0, 0, 2'b00);

        // Flush with an empty buffer must not start a write.
        flush_only();
        step();
        chk("empty_flush", {ld_busy, awvalid}, {1'b0, 1'b0});

        // Address channel stalled five cycles.
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        serve_write(5, 2, 3, 2'b00);

        // SLVERR sets the sticky error, which survives an OKAY write.
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        serve_write(0, 0, 1, 2'b10);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 4);
        serve_write(1, 0, 0, 2'b00);
        start_pulse();
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
        flush_only();
        serve_write(0, 1, 0, 2'b00);

        // Flush on the 16th byte yields exactly one full write.
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), i == 15);
        serve_write(0, 0, 0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            chk("no_extra_aw", {awvalid, ld_busy}, {1'b0, 1'b0});
            step();
        end

        // Randomized words, stalls, responses and restarts.
        for (int w = 0; w < 40; w++) begin
            if ($urandom_range(0, 9) == 0) start_pulse();
            if ($urandom_range(0, 5) == 0) flush_only();
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) step();
                fl = (i == n - 1) && ((n < 16) || ($urandom_range(0, 1) == 1));
                send_byte(8'($urandom), fl);
            end
            serve_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        // Reset while the write data beat is pending.
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        n = 0;
        while (!awvalid && n < 50) begin step(); n++; end
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("in_data", wvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data", {wvalid, awvalid, bready, ld_busy, byte_ready, ld_word_cnt},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0});
        m_addr = BASE; m_wcnt = 16'h0; m_err = 1'b0;
        m_bytes.delete(); m_exp.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst", {ld_busy, byte_ready, ld_word_cnt, ld_err}, {1'b0, 1'b1, 16'h0, 1'b0});
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), i == 3);
        serve_write(0, 0, 0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
